// File: rtl/alu_pkg.sv
// Shared ALU definitions for the EX-stage divider: op encodings, sequencer
// states and the RISC-V corner-case constants.
package alu_pkg;

    localparam int ALU_XLEN = 32;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    // Quotient returned for any divide by zero.
    localparam logic [ALU_XLEN-1:0] DIV_ZERO_Q    = '1;
    // Most negative value; dividing it by -1 overflows in signed mode.
    localparam logic [ALU_XLEN-1:0] SOVF_DIVIDEND = {1'b1, {(ALU_XLEN-1){1'b0}}};

    // Signed ops have op[0] clear.
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    // Remainder ops have op[1] set.
    function automatic logic op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/div_result_cache.sv
// Single-entry result cache: holds the operands and sign of the last division
// the core completed, together with its quotient and remainder.
module div_result_cache
    import alu_pkg::*;
#(
    parameter int XLEN = ALU_XLEN
) (
    input  logic            sys_clk,
    input  logic            sys_arstn,
    input  logic            wr_en_i,
    input  logic [XLEN-1:0] wr_dividend_i,
    input  logic [XLEN-1:0] wr_divisor_i,
    input  logic            wr_sign_i,
    input  logic [XLEN-1:0] wr_quotient_i,
    input  logic [XLEN-1:0] wr_remainder_i,
    input  logic [XLEN-1:0] lk_dividend_i,
    input  logic [XLEN-1:0] lk_divisor_i,
    input  logic            lk_sign_i,
    output logic            hit_o,
    output logic [XLEN-1:0] quotient_o,
    output logic [XLEN-1:0] remainder_o
);

    logic            valid_q, valid_d;
    logic [XLEN-1:0] dividend_q, dividend_d;
    logic [XLEN-1:0] divisor_q, divisor_d;
    logic            sign_q, sign_d;
    logic [XLEN-1:0] quot_q, quot_d;
    logic [XLEN-1:0] rem_q, rem_d;

    // Next entry: hold unless a completed core result is being written.
    always_comb begin
        valid_d    = valid_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        sign_d     = sign_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        if (wr_en_i) begin
            valid_d    = 1'b1;
            dividend_d = wr_dividend_i;
            divisor_d  = wr_divisor_i;
            sign_d     = wr_sign_i;
            quot_d     = wr_quotient_i;
            rem_d      = wr_remainder_i;
        end
    end

    // Entry storage; only reset invalidates it.
    always_ff @(posedge sys_clk or negedge sys_arstn) begin
        if (!sys_arstn) begin
            valid_q    <= 1'b0;
            dividend_q <= '0;
            divisor_q  <= '0;
            sign_q     <= 1'b0;
            quot_q     <= '0;
            rem_q      <= '0;
        end else begin
            valid_q    <= valid_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            sign_q     <= sign_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
        end
    end

    assign hit_o       = valid_q && (dividend_q == lk_dividend_i) &&
                         (divisor_q == lk_divisor_i) && (sign_q == lk_sign_i);
    assign quotient_o  = quot_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/div_sequencer.sv
// Sequencer for the iterative divider core: resolves divide-by-zero and signed
// overflow locally, reuses the cached result for repeated operands, otherwise
// runs the core under a watchdog and strobes the selected result for one cycle.
module div_sequencer
    import alu_pkg::*;
#(
    parameter int XLEN    = ALU_XLEN,
    parameter int MAX_CYC = 40
) (
    input  logic            sys_clk,
    input  logic            sys_arstn,
    input  logic            flush_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            rsp_valid_o,
    output logic [XLEN-1:0] rsp_data_o,
    output logic            busy_o,
    output logic            err_o,
    output logic            dv_start_o,
    output logic            dv_kill_o,
    output logic            dv_sign_o,
    output logic [XLEN-1:0] dv_dividend_o,
    output logic [XLEN-1:0] dv_divisor_o,
    input  logic [XLEN-1:0] dv_quotient_i,
    input  logic [XLEN-1:0] dv_remainder_i,
    input  logic            dv_finish_i
);

    localparam int            CW       = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_CYC - 1);

    div_state_e      state_q, state_d;
    logic            rem_sel_q, rem_sel_d;
    logic            sign_q, sign_d;
    logic [XLEN-1:0] dividend_q, dividend_d;
    logic [XLEN-1:0] divisor_q, divisor_d;
    logic [XLEN-1:0] quot_q, quot_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;

    logic            accept;
    logic            lk_sign;
    logic            is_div0;
    logic            is_sovf;
    logic            first_run;
    logic            finish_ok;
    logic            timeout;
    logic            cache_hit;
    logic            cache_wr;
    logic [XLEN-1:0] cache_quot;
    logic [XLEN-1:0] cache_rem;

    assign req_ready_o = (state_q == ST_IDLE) && !flush_i;
    assign accept      = req_valid_i && req_ready_o;
    assign lk_sign     = op_is_signed(op_i);
    assign is_div0     = (divisor_i == '0);
    assign is_sovf     = lk_sign && (dividend_i == SOVF_DIVIDEND) && (divisor_i == '1);
    // The cycle counter is cleared on entry to RUN, so zero marks the start cycle.
    assign first_run   = (cnt_q == '0);
    // A finish strobe coinciding with the start pulse is stale and ignored.
    assign finish_ok   = dv_finish_i && !first_run;
    assign timeout     = (cnt_q == CNT_LAST) && !finish_ok;

    div_result_cache #(
        .XLEN (XLEN)
    ) u_cache (
        .sys_clk        (sys_clk),
        .sys_arstn      (sys_arstn),
        .wr_en_i        (cache_wr),
        .wr_dividend_i  (dividend_q),
        .wr_divisor_i   (divisor_q),
        .wr_sign_i      (sign_q),
        .wr_quotient_i  (dv_quotient_i),
        .wr_remainder_i (dv_remainder_i),
        .lk_dividend_i  (dividend_i),
        .lk_divisor_i   (divisor_i),
        .lk_sign_i      (lk_sign),
        .hit_o          (cache_hit),
        .quotient_o     (cache_quot),
        .remainder_o    (cache_rem)
    );

    // Next-state, operand/result capture and the per-cycle control strobes.
    always_comb begin
        state_d     = state_q;
        rem_sel_d   = rem_sel_q;
        sign_d      = sign_q;
        dividend_d  = dividend_q;
        divisor_d   = divisor_q;
        quot_d      = quot_q;
        rem_d       = rem_q;
        cnt_d       = '0;
        err_d       = err_q;
        cache_wr    = 1'b0;
        dv_start_o  = 1'b0;
        dv_kill_o   = 1'b0;
        rsp_valid_o = 1'b0;
        busy_o      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy_o = req_valid_i && !flush_i;
                if (accept) begin
                    rem_sel_d  = op_is_rem(op_i);
                    sign_d     = lk_sign;
                    dividend_d = dividend_i;
                    divisor_d  = divisor_i;
                    if (is_div0) begin
                        quot_d  = DIV_ZERO_Q;
                        rem_d   = dividend_i;
                        state_d = ST_DONE;
                    end else if (is_sovf) begin
                        quot_d  = SOVF_DIVIDEND;
                        rem_d   = '0;
                        state_d = ST_DONE;
                    end else if (cache_hit) begin
                        quot_d  = cache_quot;
                        rem_d   = cache_rem;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                busy_o     = 1'b1;
                dv_start_o = first_run;
                if (flush_i) begin
                    dv_kill_o = 1'b1;
                    state_d   = ST_IDLE;
                end else if (finish_ok) begin
                    quot_d   = dv_quotient_i;
                    rem_d    = dv_remainder_i;
                    cache_wr = 1'b1;
                    state_d  = ST_DONE;
                end else if (timeout) begin
                    dv_kill_o = 1'b1;
                    err_d     = 1'b1;
                    quot_d    = '1;
                    rem_d     = '1;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                rsp_valid_o = !flush_i;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, operand and result registers; reset also clears the sticky error.
    always_ff @(posedge sys_clk or negedge sys_arstn) begin
        if (!sys_arstn) begin
            state_q    <= ST_IDLE;
            rem_sel_q  <= 1'b0;
            sign_q     <= 1'b0;
            dividend_q <= '0;
            divisor_q  <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_sel_q  <= rem_sel_d;
            sign_q     <= sign_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    assign rsp_data_o    = rsp_valid_o ? (rem_sel_q ? rem_q : quot_q) : '0;
    assign err_o         = err_q;
    assign dv_sign_o     = sign_q;
    assign dv_dividend_o = dividend_q;
    assign dv_divisor_o  = divisor_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: emulates the divider core, predicts every output per
// cycle from plain RISC-V division arithmetic and a one-entry operand cache.
module tb_div_sequencer;
    import alu_pkg::*;

    localparam int XLEN    = 32;
    localparam int MAX_CYC = 40;

    logic            sys_clk = 1'b0;
    logic            sys_arstn = 1'b0;
    logic            flush_i = 1'b0;
    logic            req_valid_i = 1'b0;
    logic            req_ready_o;
    logic [1:0]      op_i = 2'b00;
    logic [XLEN-1:0] dividend_i = '0;
    logic [XLEN-1:0] divisor_i = '0;
    logic            rsp_valid_o;
    logic [XLEN-1:0] rsp_data_o;
    logic            busy_o;
    logic            err_o;
    logic            dv_start_o;
    logic            dv_kill_o;
    logic            dv_sign_o;
    logic [XLEN-1:0] dv_dividend_o;
    logic [XLEN-1:0] dv_divisor_o;
    logic [XLEN-1:0] dv_quotient_i = '0;
    logic [XLEN-1:0] dv_remainder_i = '0;
    logic            dv_finish_i = 1'b0;

    always #5 sys_clk = ~sys_clk;

    div_sequencer #(
        .XLEN    (XLEN),
        .MAX_CYC (MAX_CYC)
    ) dut (
        .sys_clk        (sys_clk),
        .sys_arstn      (sys_arstn),
        .flush_i        (flush_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .op_i           (op_i),
        .dividend_i     (dividend_i),
        .divisor_i      (divisor_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_data_o     (rsp_data_o),
        .busy_o         (busy_o),
        .err_o          (err_o),
        .dv_start_o     (dv_start_o),
        .dv_kill_o      (dv_kill_o),
        .dv_sign_o      (dv_sign_o),
        .dv_dividend_o  (dv_dividend_o),
        .dv_divisor_o   (dv_divisor_o),
        .dv_quotient_i  (dv_quotient_i),
        .dv_remainder_i (dv_remainder_i),
        .dv_finish_i    (dv_finish_i)
    );

    int checks = 0;
    int failures = 0;

    // Per-cycle expectations, written by the driver, read by the compare process.
    logic            check_en = 1'b0;
    logic            exp_ready = 1'b1, exp_busy = 1'b0, exp_rsp_valid = 1'b0;
    logic            exp_start = 1'b0, exp_kill = 1'b0, exp_run = 1'b0, exp_err = 1'b0;
    logic [XLEN-1:0] exp_rsp_data = '0, exp_dv_a = '0, exp_dv_b = '0;
    logic            exp_dv_sign = 1'b0;

    // Model of the single remembered operand set.
    logic            mc_valid = 1'b0;
    logic [XLEN-1:0] mc_a = '0, mc_b = '0;
    logic            mc_sign = 1'b0;

    int              start_count = 0;
    logic [XLEN-1:0] last_rsp = '0;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // RISC-V M-extension division semantics.
    function automatic void ref_divrem(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                       output logic [XLEN-1:0] q, output logic [XLEN-1:0] r);
        if (b == 0) begin
            q = '1;
            r = a;
        end else if (!op[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = a;
                r = '0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    function automatic logic [XLEN-1:0] ref_result(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        logic [XLEN-1:0] q, r;
        ref_divrem(op, a, b, q, r);
        return op[1] ? r : q;
    endfunction

    // Compare every output against the model on each falling edge.
    always @(negedge sys_clk) begin
        if (check_en) begin
            check("req_ready", 32'(req_ready_o), 32'(exp_ready));
            check("busy", 32'(busy_o), 32'(exp_busy));
            check("rsp_valid", 32'(rsp_valid_o), 32'(exp_rsp_valid));
            if (exp_rsp_valid) check("rsp_data", rsp_data_o, exp_rsp_data);
            check("dv_start", 32'(dv_start_o), 32'(exp_start));
            check("dv_kill", 32'(dv_kill_o), 32'(exp_kill));
            check("err", 32'(err_o), 32'(exp_err));
            if (exp_run) begin
                check("dv_dividend", dv_dividend_o, exp_dv_a);
                check("dv_divisor", dv_divisor_o, exp_dv_b);
                check("dv_sign", 32'(dv_sign_o), 32'(exp_dv_sign));
            end
            if (rsp_valid_o) last_rsp = rsp_data_o;
            if (dv_start_o) start_count++;
        end
    end

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic set_exp(input logic rdy, input logic bsy, input logic rv, input logic [XLEN-1:0] data,
                           input logic st, input logic kl, input logic run);
        exp_ready = rdy;
        exp_busy = bsy;
        exp_rsp_valid = rv;
        exp_rsp_data = data;
        exp_start = st;
        exp_kill = kl;
        exp_run = run;
    endtask

    task automatic idle(input int n);
        set_exp(1, 0, 0, '0, 0, 0, 0);
        for (int i = 0; i < n; i++) step();
    endtask

    // One request. lat<0: core never finishes. flush_at: RUN cycle index to flush (<=0 none).
    task automatic do_req(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input int lat, input int flush_at, input bit flush_done, input bit spurious);
        logic [XLEN-1:0] q, r, res;
        bit sgn, special, hit, done, killed, fin;
        int j;
        sgn = !op[0];
        ref_divrem(op, a, b, q, r);
        res = op[1] ? r : q;
        special = (b == 0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        hit = !special && mc_valid && mc_a == a && mc_b == b && mc_sign == sgn;
        req_valid_i = 1; op_i = op; dividend_i = a; divisor_i = b; flush_i = 0;
        set_exp(1, 1, 0, '0, 0, 0, 0);
        step();
        req_valid_i = 0; op_i = 2'($urandom); dividend_i = $urandom; divisor_i = $urandom;
        killed = 0;
        if (!(special || hit)) begin
            exp_dv_a = a; exp_dv_b = b; exp_dv_sign = sgn;
            j = 1; done = 0;
            while (!done) begin
                fin = (lat >= 0 && j == 1 + lat) || (j == 1 && spurious);
                flush_i = (j == flush_at);
                dv_finish_i = fin;
                dv_quotient_i = (fin && j > 1) ? q : $urandom;
                dv_remainder_i = (fin && j > 1) ? r : $urandom;
                if (flush_i) begin
                    set_exp(0, 1, 0, '0, j == 1, 1, 1);
                    step();
                    killed = 1; done = 1;
                end else if (fin && j > 1) begin
                    set_exp(0, 1, 0, '0, 0, 0, 1);
                    step();
                    mc_valid = 1; mc_a = a; mc_b = b; mc_sign = sgn;
                    done = 1;
                end else if (j == MAX_CYC) begin
                    set_exp(0, 1, 0, '0, j == 1, 1, 1);
                    step();
                    exp_err = 1; res = '1; done = 1;
                end else begin
                    set_exp(0, 1, 0, '0, j == 1, 0, 1);
                    step();
                    j++;
                end
            end
            dv_finish_i = 0; flush_i = 0;
            dv_quotient_i = $urandom; dv_remainder_i = $urandom;
        end
        if (!killed) begin
            flush_i = flush_done;
            set_exp(0, 0, !flush_done, res, 0, 0, 0);
            step();
            flush_i = 0;
        end
        set_exp(1, 0, 0, '0, 0, 0, 0);
    endtask

    function automatic logic [XLEN-1:0] pick(input logic [XLEN-1:0] prev);
        case ($urandom_range(0, 5))
            0: return $urandom;
            1: return $urandom_range(0, 20);
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            4: return '0;
            default: return prev;
        endcase
    endfunction

    initial begin
        int sc;
        logic [XLEN-1:0] ra, rb;
        int lat, fa;

        // Pin the reference arithmetic to hand-computed values.
        check("model_divu_100_7", ref_result(OP_DIVU, 100, 7), 32'd14);
        check("model_remu_100_7", ref_result(OP_REMU, 100, 7), 32'd2);
        check("model_div_sovf", ref_result(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
        check("model_rem_div0", ref_result(OP_REM, 32'h1234, 0), 32'h1234);
        check("model_div_m20_3", ref_result(OP_DIV, 32'hFFFF_FFEC, 3), 32'hFFFF_FFFA);
        check("model_rem_m20_3", ref_result(OP_REM, 32'hFFFF_FFEC, 3), 32'hFFFF_FFFE);

        // Reset state.
        set_exp(1, 0, 0, '0, 0, 0, 0);
        check_en = 1;
        step(); step();
        check("reset_dv_dividend", dv_dividend_o, '0);
        check("reset_dv_divisor", dv_divisor_o, '0);
        sys_arstn = 1;
        idle(2);

        // Normal run, then a cache hit selecting the remainder.
        sc = start_count;
        do_req(OP_DIVU, 100, 7, 5, 0, 0, 0);
        check("divu_100_7_result", last_rsp, 32'd14);
        check("divu_100_7_starts", 32'(start_count - sc), 32'd1);
        sc = start_count;
        do_req(OP_REMU, 100, 7, 5, 0, 0, 0);
        check("remu_100_7_hit_result", last_rsp, 32'd2);
        check("remu_100_7_hit_starts", 32'(start_count - sc), 32'd0);

        // Signed overflow and divide by zero bypass the core.
        sc = start_count;
        do_req(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 3, 0, 0, 0);
        check("div_sovf_result", last_rsp, 32'h8000_0000);
        do_req(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 3, 0, 0, 0);
        check("rem_sovf_result", last_rsp, 32'h0);
        do_req(OP_REM, 32'h1234, 0, 3, 0, 0, 0);
        check("rem_div0_result", last_rsp, 32'h1234);
        do_req(OP_DIVU, 5, 0, 3, 0, 0, 0);
        check("divu_div0_result", last_rsp, 32'hFFFF_FFFF);
        check("special_starts", 32'(start_count - sc), 32'd0);

        // Flush three cycles after start, then the same request must miss.
        do_req(OP_DIV, 32'hFFFF_FFEC, 3, 8, 4, 0, 0);
        idle(1);
        sc = start_count;
        do_req(OP_DIV, 32'hFFFF_FFEC, 3, 3, 0, 0, 1);
        check("div_m20_3_result", last_rsp, 32'hFFFF_FFFA);
        check("div_m20_3_starts", 32'(start_count - sc), 32'd1);

        // Flush while idle blocks acceptance; flush in DONE hides the strobe.
        req_valid_i = 1; flush_i = 1; op_i = OP_DIVU; dividend_i = 9; divisor_i = 0;
        set_exp(0, 0, 0, '0, 0, 0, 0);
        step();
        req_valid_i = 0; flush_i = 0;
        idle(2);
        do_req(OP_DIVU, 9, 0, 3, 0, 1, 0);
        idle(1);

        // Randomized traffic.
        ra = 32'd50; rb = 32'd3;
        for (int n = 0; n < 250; n++) begin
            ra = pick(ra);
            rb = pick(rb);
            lat = $urandom_range(1, 12);
            fa = ($urandom_range(0, 9) == 0) ? $urandom_range(2, lat + 1) : 0;
            do_req(2'($urandom), ra, rb, lat, fa, $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
            idle($urandom_range(0, 2));
        end

        // Watchdog: the core never finishes.
        sc = start_count;
        do_req(OP_DIVU, 32'h0BAD_F00D, 32'h1357_9BDF, -1, 0, 0, 0);
        check("watchdog_result", last_rsp, 32'hFFFF_FFFF);
        check("watchdog_err", 32'(err_o), 32'd1);
        do_req(OP_DIVU, 32'd77, 32'd5, 2, 0, 0, 0);
        check("watchdog_err_sticky", 32'(err_o), 32'd1);

        // Reset mid-RUN forgets the cached operands and clears the error.
        do_req(OP_DIVU, 32'd1000, 32'd10, 2, 0, 0, 0);
        idle(1);
        req_valid_i = 1; op_i = OP_DIVU; dividend_i = 32'd999; divisor_i = 32'd10;
        set_exp(1, 1, 0, '0, 0, 0, 0);
        step();
        req_valid_i = 0;
        exp_dv_a = 32'd999; exp_dv_b = 32'd10; exp_dv_sign = 0;
        set_exp(0, 1, 0, '0, 1, 0, 1);
        step();
        set_exp(0, 1, 0, '0, 0, 0, 1);
        step(); step();
        sys_arstn = 0;
        set_exp(1, 0, 0, '0, 0, 0, 0);
        exp_err = 0;
        mc_valid = 0;
        #1;
        check("arst_dv_dividend", dv_dividend_o, '0);
        check("arst_dv_sign", 32'(dv_sign_o), 32'd0);
        check("arst_err", 32'(err_o), 32'd0);
        step();
        sys_arstn = 1;
        idle(1);
        sc = start_count;
        do_req(OP_DIVU, 32'd1000, 32'd10, 4, 0, 0, 0);
        check("post_reset_miss_starts", 32'(start_count - sc), 32'd1);
        check("post_reset_result", last_rsp, 32'd100);
        idle(2);

        check_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
